demux1hot_reg: RTL and testbench
================================

# demux1hot_reg

Registered one-hot demultiplexer. It steers a single valid/ready input stream to one of `OUTPUTS` destination streams, selected by a one-hot destination vector. Each destination has a one-entry output register. It is the distribution counterpart of the one-hot mux: the mux gathers N sources into one, and this block fans one source out to N sinks with independent back-pressure. It sits between a producer and a bank of per-lane consumers.

## Interface
Parameters:
- `OUTPUTS`, default 2: number of destinations; legal values are ≥2.
- `WIDTH`, default 1: payload width in bits.

Ports:
- `clk`, in, 1: the single clock; all state is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: input beat accepted when high together with `in_valid`.
- `in_data`, in, `WIDTH`: input payload.
- `in_sel`, in, `OUTPUTS`: one-hot destination vector, sampled with the beat.
- `out_valid`, out, `OUTPUTS`: per-destination valid.
- `out_ready`, in, `OUTPUTS`: per-destination ready.
- `out_data`, out, `WIDTH*OUTPUTS`: packed payloads; lane i occupies `[i*WIDTH +: WIDTH]`.
- `err_pulse`, out, 1: illegal select dropped (present only with `DEMUX1HOT_CHECK_EN`).
- `err_cnt`, out, 8: saturating count of illegal selects (present only with `DEMUX1HOT_CHECK_EN`).

## Operation
- Each lane i has a slot, `vld[i]`/`dat[i]`. Lane i is free when `!vld[i] || out_ready[i]`.
- `in_ready` is combinational: 1 when every lane selected by `in_sel` is free. With zero-hot `in_sel`, `in_ready` is 1.
- Accept = `in_valid && in_ready`. On accept, every selected lane loads `dat[i]=in_data` and sets `vld[i]=1`.
- Non-selected lanes with `vld[i] && out_ready[i]` clear `vld[i]`. The `dat` of non-loaded lanes holds its value.
- A lane that drains and reloads in the same cycle stays valid with the new data. This gives full throughput of one beat per cycle per lane.
- `out_valid[i]=vld[i]` and `out_data` lane i equals `dat[i]`, both direct from registers.
- Lanes are independent. A stalled lane blocks only beats that target it.
- Without the check feature:
  - Multi-hot `in_sel` broadcasts to all selected lanes, and is accepted only when all of them are free.
  - Zero-hot `in_sel` is accepted and discarded.

## Timing
- Reset (async assert): `vld` is cleared to all-0 and `dat` to all-0 immediately. `out_valid`=0 and `out_data`=0. `err_cnt`=0 and `err_pulse`=0.
- While `rst` is high, `in_ready`=0. After deassertion, `in_ready` follows the rule above; all lanes are free.
- Latency: a beat accepted at edge k gives `out_valid[i]`=1 from edge k (visible in cycle k+1). The minimum input-to-output delay is 1 cycle.
- `out_valid[i]`, once high, stays high and `dat[i]` stays stable until the cycle where `out_ready[i]`=1.
- `in_ready` depends combinationally on `out_ready` and `in_sel`. It never depends on `in_valid`.
- Reset asserted mid-transfer drops all held beats; nothing is replayed.

## Configuration
- Macro: `DEMUX1HOT_CHECK_EN`.
- Defined:
  - `in_sel` with a popcount other than 1 is illegal. An illegal beat is always accepted (`in_ready`=1), written to no lane, and raises `err_pulse` for exactly the accept cycle (registered, so it is visible the cycle after).
  - `err_cnt` increments per illegal accept and saturates at 255.
  - Legal beats behave as normal.
- Undefined: the `err_*` ports and the counter are absent. Multi-hot and zero-hot selects follow the Operation rules.

## Structure
- Package `demux1hot_pkg` holds:
  - the `is_onehot` function (popcount == 1);
  - the `ERR_CNT_W = 8` constant.
- Sub-module `demux1hot_slot` is a one-entry register with ports `clk`, `rst`, `load`, `ld_data`, `out_valid`, `out_ready`, `out_data` and `free`. It is instantiated `OUTPUTS` times in a generate loop.
- The top level contains only the select/accept logic and the optional error counter.

## Test plan
- Reset mid-stream (`OUTPUTS`=4, `WIDTH`=8):
  - lane 2 holds 0x5A when `rst` asserts → `out_valid`=0000 and `out_data`=0 immediately;
  - `in_ready`=1 the first cycle after release with `in_sel`=0100.
- Streaming: send 0x01, 0x02, 0x03 to lane 1 with `out_ready[1]`=1 on consecutive cycles → lane 1 presents 0x01, 0x02, 0x03 one cycle later each, with no bubbles.
- Back-pressure isolation:
  - lane 0 is full and `out_ready[0]`=0;
  - a beat to lane 0 sees `in_ready`=0;
  - a next beat 0xAA with `in_sel`=0010 is accepted and appears on lane 1 while lane 0 still holds its data.
- Simultaneous drain and load: lane 3 holds 0x10 and `out_ready[3]`=1 while 0x20 is accepted for lane 3 → next cycle `out_valid[3]`=1 and the data is 0x20.
- Broadcast (macro undefined): `in_sel`=0011 with 0x77, lane 1 full and stalled → `in_ready`=0. After lane 1 drains, both lanes get 0x77.
- Illegal select (macro defined):
  - `in_sel`=0000, then 0110 → both are accepted, no lane loads, and `err_pulse` fires twice, giving `err_cnt`=2;
  - 300 illegal beats → `err_cnt`=255.

Source files
------------

// File: rtl/demux1hot_pkg.sv
// Shared constants and helpers for the registered one-hot demultiplexer.
package demux1hot_pkg;

  // Widest destination vector the select helper accepts; callers zero-extend.
  localparam int MAX_SEL_W = 64;
  localparam int ERR_CNT_W = 8;

  function automatic logic is_onehot(input logic [MAX_SEL_W-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_SEL_W; i++) begin
      cnt += int'(v[i]);
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/demux1hot_slot.sv
// One-entry output register for a single demux lane; a drain and a reload
// in the same cycle keep the lane valid with the new payload.
module demux1hot_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             free
);

  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (load) begin
      r_vld <= 1'b1;
      r_dat <= ld_data;
    end else if (out_ready) begin
      r_vld <= 1'b0;
    end
  end

  assign free      = !r_vld || out_ready;
  assign out_valid = r_vld;
  assign out_data  = r_dat;

endmodule

// File: rtl/demux1hot_reg.sv
// Registered one-hot demultiplexer: one valid/ready source fanned out to
// OUTPUTS independently back-pressured lanes. Define DEMUX1HOT_CHECK_EN to
// drop non-one-hot selects and count them on err_pulse/err_cnt.
module demux1hot_reg
  import demux1hot_pkg::*;
#(
  parameter int OUTPUTS = 2,
  parameter int WIDTH   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [OUTPUTS-1:0]       in_sel,
  output logic [OUTPUTS-1:0]       out_valid,
  input  logic [OUTPUTS-1:0]       out_ready,
  output logic [WIDTH*OUTPUTS-1:0] out_data
`ifdef DEMUX1HOT_CHECK_EN
  ,
  output logic                     err_pulse,
  output logic [ERR_CNT_W-1:0]     err_cnt
`endif
);

  logic [OUTPUTS-1:0] w_free;
  logic [OUTPUTS-1:0] w_load;
  logic               w_all_free;
  logic               w_accept;

  // Every lane the beat targets must be able to take it this cycle.
  assign w_all_free = &(w_free | ~in_sel);

`ifdef DEMUX1HOT_CHECK_EN
  logic                 w_legal;
  logic                 w_illegal_acc;
  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  assign w_legal       = is_onehot(MAX_SEL_W'(in_sel));
  assign in_ready      = !rst && (!w_legal || w_all_free);
  assign w_accept      = in_valid && in_ready;
  assign w_illegal_acc = w_accept && !w_legal;
  assign w_load        = (w_accept && w_legal) ? in_sel : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_illegal_acc;
      if (w_illegal_acc && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
`else
  // Multi-hot broadcasts; zero-hot is accepted and lands nowhere.
  assign in_ready = !rst && w_all_free;
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept ? in_sel : '0;
`endif

  for (genvar g = 0; g < OUTPUTS; g++) begin : g_lane
    demux1hot_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load[g]),
      .ld_data   (in_data),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g*WIDTH +: WIDTH]),
      .free      (w_free[g])
    );
  end

endmodule

// File: tb/tb_demux1hot_reg.sv
// Directed self-checking bench for demux1hot_reg with 4 lanes of 8 bits.
module tb_demux1hot_reg;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [N-1:0]   in_sel;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [W*N-1:0] out_data;
`ifdef DEMUX1HOT_CHECK_EN
  logic           err_pulse;
  logic [7:0]     err_cnt;
`endif

  int checks;
  int errors;

  demux1hot_reg #(.OUTPUTS(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX1HOT_CHECK_EN
    ,
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] lane(input int i);
    return out_data[i*W +: W];
  endfunction

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = '0;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_in_ready_low", 32'(in_ready), 32'h0);
    rst = 1'b0;

    // Fill lane 2 with 0x5A and hold it
    in_valid = 1'b1; in_sel = 4'b0100; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    chk("hold_lane2_valid", 32'(out_valid), 32'b0100);
    chk("hold_lane2_data", 32'(lane(2)), 32'h5A);

    // Asynchronous reset in mid-cycle clears everything immediately
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'h0);
    chk("async_rst_data", 32'(out_data), 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    in_sel = 4'b0100;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    tick();
    chk("post_rst_no_replay", 32'(out_valid), 32'h0);

    // Streaming three beats to lane 1 with the sink always ready
    out_ready = 4'b0010; in_sel = 4'b0010; in_valid = 1'b1; in_data = 8'h01;
    tick();
    chk("stream_v1", 32'(out_valid), 32'b0010);
    chk("stream_d1", 32'(lane(1)), 32'h01);
    in_data = 8'h02;
    tick();
    chk("stream_v2", 32'(out_valid), 32'b0010);
    chk("stream_d2", 32'(lane(1)), 32'h02);
    in_data = 8'h03;
    tick();
    chk("stream_v3", 32'(out_valid), 32'b0010);
    chk("stream_d3", 32'(lane(1)), 32'h03);
    in_valid = 1'b0;
    tick();
    chk("stream_drained", 32'(out_valid), 32'h0);

    // Back-pressure isolation: stalled lane 0 blocks only its own beats
    out_ready = 4'b0000; in_sel = 4'b0001; in_valid = 1'b1; in_data = 8'h33;
    tick();
    chk("bp_lane0_valid", 32'(out_valid), 32'b0001);
    chk("bp_lane0_data", 32'(lane(0)), 32'h33);
    in_data = 8'h44;
    #1;
    chk("bp_lane0_blocked", 32'(in_ready), 32'h0);
    tick();
    chk("bp_lane0_kept", 32'(lane(0)), 32'h33);
    in_sel = 4'b0010; in_data = 8'hAA;
    #1;
    chk("bp_lane1_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_both_valid", 32'(out_valid), 32'b0011);
    chk("bp_lane1_data", 32'(lane(1)), 32'hAA);
    chk("bp_lane0_still", 32'(lane(0)), 32'h33);
    out_ready = 4'b1111;
    tick();
    chk("bp_cleared", 32'(out_valid), 32'h0);

    // Drain and reload lane 3 in the same cycle
    out_ready = 4'b0000; in_sel = 4'b1000; in_valid = 1'b1; in_data = 8'h10;
    tick();
    chk("dl_first", 32'(lane(3)), 32'h10);
    out_ready = 4'b1000; in_data = 8'h20;
    #1;
    chk("dl_in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("dl_valid", 32'(out_valid), 32'b1000);
    chk("dl_data", 32'(lane(3)), 32'h20);
    tick();
    chk("dl_drained", 32'(out_valid), 32'h0);

`ifndef DEMUX1HOT_CHECK_EN
    // Broadcast waits for every selected lane to be free
    out_ready = 4'b0000; in_sel = 4'b0010; in_valid = 1'b1; in_data = 8'h55;
    tick();
    in_sel = 4'b0011; in_data = 8'h77;
    #1;
    chk("bc_blocked", 32'(in_ready), 32'h0);
    tick();
    chk("bc_no_load", 32'(out_valid), 32'b0010);
    chk("bc_lane1_kept", 32'(lane(1)), 32'h55);
    out_ready = 4'b0010;
    #1;
    chk("bc_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0; out_ready = 4'b0000;
    chk("bc_valid", 32'(out_valid), 32'b0011);
    chk("bc_lane0", 32'(lane(0)), 32'h77);
    chk("bc_lane1", 32'(lane(1)), 32'h77);
    out_ready = 4'b1111;
    tick();
    // Zero-hot beat is accepted and lands nowhere
    out_ready = 4'b0000; in_sel = 4'b0000; in_valid = 1'b1; in_data = 8'h99;
    #1;
    chk("zh_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("zh_no_load", 32'(out_valid), 32'h0);
`else
    // Illegal selects are swallowed and counted
    out_ready = 4'b0000; in_sel = 4'b0000; in_valid = 1'b1; in_data = 8'h99;
    #1;
    chk("ill_zero_ready", 32'(in_ready), 32'h1);
    tick();
    chk("ill_zero_pulse", 32'(err_pulse), 32'h1);
    chk("ill_zero_cnt", 32'(err_cnt), 32'd1);
    in_sel = 4'b0110;
    #1;
    chk("ill_multi_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    chk("ill_multi_pulse", 32'(err_pulse), 32'h1);
    chk("ill_multi_cnt", 32'(err_cnt), 32'd2);
    chk("ill_no_load", 32'(out_valid), 32'h0);
    tick();
    chk("ill_pulse_low", 32'(err_pulse), 32'h0);
    chk("ill_cnt_hold", 32'(err_cnt), 32'd2);
    in_sel = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    chk("ill_cnt_sat", 32'(err_cnt), 32'd255);
    chk("ill_sat_no_load", 32'(out_valid), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
